// File: rtl/stage_ex_pkg.sv
// Shared definitions for the execute stage: operation/category codes, stall and write levels,
// and the divider state encoding.
package stage_ex_pkg;

   localparam logic [7:0] OP_NOP   = 8'b0000_0000;
   localparam logic [7:0] OP_AND   = 8'b0010_0100;
   localparam logic [7:0] OP_OR    = 8'b0010_0101;
   localparam logic [7:0] OP_XOR   = 8'b0010_0110;
   localparam logic [7:0] OP_NOR   = 8'b0010_0111;
   localparam logic [7:0] OP_SLL   = 8'b0111_1100;
   localparam logic [7:0] OP_SRL   = 8'b0000_0010;
   localparam logic [7:0] OP_SRA   = 8'b0000_0011;
   localparam logic [7:0] OP_ADD   = 8'b0010_0000;
   localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
   localparam logic [7:0] OP_SUB   = 8'b0010_0010;
   localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
   localparam logic [7:0] OP_ADDI  = 8'b0101_0101;
   localparam logic [7:0] OP_ADDIU = 8'b0101_0110;
   localparam logic [7:0] OP_SLT   = 8'b0010_1010;
   localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
   localparam logic [7:0] OP_LW    = 8'b1110_0011;
   localparam logic [7:0] OP_MULT  = 8'b0001_1000;
   localparam logic [7:0] OP_MULTU = 8'b0001_1001;
   localparam logic [7:0] OP_DIV   = 8'b0001_1010;
   localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
   localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
   localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
   localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
   localparam logic [7:0] OP_MTLO  = 8'b0001_0011;

   localparam logic [2:0] CATEGORY_NONE   = 3'd0;
   localparam logic [2:0] CATEGORY_LOGIC  = 3'd1;
   localparam logic [2:0] CATEGORY_SHIFT  = 3'd2;
   localparam logic [2:0] CATEGORY_ARITH  = 3'd3;
   localparam logic [2:0] CATEGORY_MOVE   = 3'd4;
   localparam logic [2:0] CATEGORY_JUMP   = 3'd5;
   localparam logic [2:0] CATEGORY_MEMORY = 3'd6;

   localparam int unsigned STALL_EX  = 3;
   localparam int unsigned STALL_MEM = 4;
   localparam logic STALL_ON  = 1'b1;
   localparam logic STALL_OFF = 1'b0;

   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

   typedef enum logic [1:0] {DivIdle, DivRun, DivZero, DivDone} div_state_e;

   function automatic logic [31:0] sign_extend16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/stage_ex_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage. The pipeline side uses master,
// the execute stage uses slave.
interface stage_ex_if;
   logic [31:0] ex_instruction;
   logic [7:0]  ex_operator;
   logic [2:0]  ex_category;
   logic [31:0] ex_operand_a;
   logic [31:0] ex_operand_b;
   logic        ex_reg_write_enable;
   logic [4:0]  ex_reg_write_address;
   logic [31:0] ex_reg_write_data;

   logic [31:0] mem_instruction;
   logic [7:0]  mem_operator;
   logic [31:0] mem_address;
   logic [31:0] mem_store_data;
   logic        mem_reg_write_enable;
   logic [4:0]  mem_reg_write_address;
   logic [31:0] mem_reg_write_data;
   logic        overflow;
   logic        stall_request;

   modport master (
      output ex_instruction, ex_operator, ex_category, ex_operand_a, ex_operand_b,
             ex_reg_write_enable, ex_reg_write_address, ex_reg_write_data,
      input  mem_instruction, mem_operator, mem_address, mem_store_data,
             mem_reg_write_enable, mem_reg_write_address, mem_reg_write_data,
             overflow, stall_request
   );

   modport slave (
      input  ex_instruction, ex_operator, ex_category, ex_operand_a, ex_operand_b,
             ex_reg_write_enable, ex_reg_write_address, ex_reg_write_data,
      output mem_instruction, mem_operator, mem_address, mem_store_data,
             mem_reg_write_enable, mem_reg_write_address, mem_reg_write_data,
             overflow, stall_request
   );
endinterface

// File: rtl/ex_divider.sv
// Iterative radix-2 restoring divider on operand magnitudes; signs are applied to the held
// result once the iteration is finished.
module ex_divider
   import stage_ex_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        is_signed,
   input  logic        cancel,
   input  logic        hold,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   localparam int unsigned CntW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DIV_CYCLES - 1);

   div_state_e state_q, state_d;
   logic [CntW-1:0] count_q;
   logic [31:0] rem_q, quo_q, den_q;
   logic        quo_neg_q, rem_neg_q;

   logic        dividend_neg, divisor_neg;
   logic [31:0] dividend_mag, divisor_mag;
   logic [32:0] partial;
   logic [33:0] trial;
   logic [31:0] rem_next, quo_next;

   always_ff @(posedge clock) begin
      if (reset) state_q <= DivIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (cancel) begin
         state_d = DivIdle;
      end else begin
         unique case (state_q)
            DivIdle: if (start) state_d = (divisor == 32'd0) ? DivZero : DivRun;
            DivRun:  if (count_q == CntLast) state_d = DivDone;
            DivZero: state_d = DivDone;
            DivDone: if (!hold) state_d = DivIdle;
            default: state_d = DivIdle;
         endcase
      end
   end

   always_comb begin
      done      = (state_q == DivDone);
      quotient  = quo_neg_q ? (32'd0 - quo_q) : quo_q;
      remainder = rem_neg_q ? (32'd0 - rem_q) : rem_q;
   end

   always_comb begin
      dividend_neg = is_signed & dividend[31];
      divisor_neg  = is_signed & divisor[31];
      dividend_mag = dividend_neg ? (32'd0 - dividend) : dividend;
      divisor_mag  = divisor_neg ? (32'd0 - divisor) : divisor;
      // Partial remainder can reach 33 bits for large unsigned divisors; trial keeps a borrow bit.
      partial  = {rem_q, quo_q[31]};
      trial    = {1'b0, partial} - {2'b00, den_q};
      rem_next = trial[33] ? partial[31:0] : trial[31:0];
      quo_next = {quo_q[30:0], ~trial[33]};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q   <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         den_q     <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
      end else if (state_q == DivIdle && start) begin
         count_q   <= '0;
         rem_q     <= '0;
         quo_q     <= (divisor == 32'd0) ? 32'd0 : dividend_mag;
         den_q     <= divisor_mag;
         quo_neg_q <= dividend_neg ^ divisor_neg;
         rem_neg_q <= dividend_neg;
      end else if (state_q == DivRun) begin
         count_q <= count_q + CntW'(1);
         rem_q   <= rem_next;
         quo_q   <= quo_next;
      end
   end

endmodule

// File: rtl/stage_ex.sv
// MIPS execute stage: ALU/shift/compare/link results, memory address, and the HI/LO pair
// fed by a single-cycle multiplier and the iterative divider.
module stage_ex
   import stage_ex_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] stall,
   input  logic       cancel,
   stage_ex_if.slave  bus
);

   logic [31:0] a, b;
   logic [7:0]  op;
   logic [31:0] hi_q, lo_q;
   logic [31:0] sum, diff, result;
   logic [63:0] prod_signed, prod_unsigned;
   logic        is_div, ex_hold, div_done, ovf;
   logic [31:0] div_quotient, div_remainder;
   logic        unused_stall;

   assign a       = bus.ex_operand_a;
   assign b       = bus.ex_operand_b;
   assign op      = bus.ex_operator;
   assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
   assign ex_hold = (stall[STALL_EX] == STALL_ON);
   assign unused_stall = ^{stall[5], stall[STALL_MEM], stall[2:0]};

   ex_divider #(
      .DIV_CYCLES(DIV_CYCLES)
   ) u_divider (
      .clock     (clock),
      .reset     (reset),
      .start     (is_div),
      .is_signed (op == OP_DIV),
      .cancel    (cancel),
      .hold      (ex_hold),
      .dividend  (a),
      .divisor   (b),
      .done      (div_done),
      .quotient  (div_quotient),
      .remainder (div_remainder)
   );

   assign sum           = a + b;
   assign diff          = a - b;
   assign prod_signed   = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
   assign prod_unsigned = {32'd0, a} * {32'd0, b};

   always_comb begin
      ovf = 1'b0;
      if (op == OP_ADD || op == OP_ADDI) ovf = (a[31] == b[31]) && (sum[31] != a[31]);
      else if (op == OP_SUB)             ovf = (a[31] != b[31]) && (diff[31] != a[31]);
   end

   always_comb begin
      result = '0;
      case (bus.ex_category)
         CATEGORY_LOGIC: begin
            case (op)
               OP_AND:  result = a & b;
               OP_OR:   result = a | b;
               OP_XOR:  result = a ^ b;
               OP_NOR:  result = ~(a | b);
               default: result = '0;
            endcase
         end
         CATEGORY_SHIFT: begin
            case (op)
               OP_SLL:  result = b << a[4:0];
               OP_SRL:  result = b >> a[4:0];
               OP_SRA:  result = 32'($signed(b) >>> a[4:0]);
               default: result = '0;
            endcase
         end
         CATEGORY_ARITH: begin
            case (op)
               OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: result = sum;
               OP_SUB, OP_SUBU:                    result = diff;
               OP_SLT:  result = {31'd0, $signed(a) < $signed(b)};
               OP_SLTU: result = {31'd0, a < b};
               default: result = '0;
            endcase
         end
         CATEGORY_MOVE: begin
            case (op)
               OP_MFHI: result = hi_q;
               OP_MFLO: result = lo_q;
               default: result = '0;
            endcase
         end
         CATEGORY_JUMP: result = bus.ex_reg_write_data;
         default:       result = '0;
      endcase
   end

   // A held or flushed instruction must not touch HI/LO; a divide commits on its DONE exit edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (!ex_hold && !cancel) begin
         case (op)
            OP_MULT:  {hi_q, lo_q} <= prod_signed;
            OP_MULTU: {hi_q, lo_q} <= prod_unsigned;
            OP_MTHI:  hi_q <= a;
            OP_MTLO:  lo_q <= a;
            OP_DIV, OP_DIVU: begin
               if (div_done) begin
                  hi_q <= div_remainder;
                  lo_q <= div_quotient;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_instruction       = bus.ex_instruction;
   assign bus.mem_operator          = op;
   assign bus.mem_address           = a + sign_extend16(bus.ex_instruction[15:0]);
   assign bus.mem_store_data        = b;
   assign bus.mem_reg_write_enable  = ovf ? WRITE_DISABLE : bus.ex_reg_write_enable;
   assign bus.mem_reg_write_address = bus.ex_reg_write_address;
   assign bus.mem_reg_write_data    = result;
   assign bus.overflow              = ovf;
   assign bus.stall_request         = is_div && !div_done;

endmodule

// File: tb/tb_stage_ex.sv
// Directed bench for stage_ex: expected results are queued as stimulus is driven and popped
// when the stage output is sampled.
module tb_stage_ex;
   import stage_ex_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic [5:0] stall;
   logic       cancel;

   always #5 clock = ~clock;

   stage_ex_if bus ();

   stage_ex #(
      .DIV_CYCLES(32)
   ) u_dut (
      .clock  (clock),
      .reset  (reset),
      .stall  (stall),
      .cancel (cancel),
      .bus    (bus)
   );

   typedef struct {
      string       tag;
      logic [31:0] data;
      logic        we;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   stall_sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [7:0] o, input logic [2:0] cat, input logic [31:0] a,
                        input logic [31:0] b, input logic we, input logic [31:0] wd,
                        input logic [15:0] imm);
      bus.ex_instruction       = {16'h0000, imm};
      bus.ex_operator          = o;
      bus.ex_category          = cat;
      bus.ex_operand_a         = a;
      bus.ex_operand_b         = b;
      bus.ex_reg_write_enable  = we;
      bus.ex_reg_write_address = 5'd8;
      bus.ex_reg_write_data    = wd;
   endtask

   // Drive one non-divide op, queue its expected result, then pop and compare once settled.
   task automatic exec(input string tag, input logic [7:0] o, input logic [2:0] cat,
                       input logic [31:0] a, input logic [31:0] b, input logic we,
                       input logic [31:0] wd, input logic [15:0] imm,
                       input logic [31:0] edata, input logic ewe, input logic eovf);
      exp_t e;
      drive(o, cat, a, b, we, wd, imm);
      sb.push_back('{tag, edata, ewe, eovf});
      #1;
      e = sb.pop_front();
      chk({e.tag, ".data"}, bus.mem_reg_write_data, e.data);
      chk({e.tag, ".we"}, 32'(bus.mem_reg_write_enable), 32'(e.we));
      chk({e.tag, ".ovf"}, 32'(bus.overflow), 32'(e.ovf));
      chk({e.tag, ".stall_req"}, 32'(bus.stall_request), 32'd0);
   endtask

   task automatic div_issue(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                            input int exp_cycles);
      drive(o, CATEGORY_NONE, a, b, 1'b0, 32'd0, 16'h0000);
      stall_sb.push_back(exp_cycles);
   endtask

   // Counts stall_request cycles; leaves the bench in the first cycle with it low.
   task automatic measure_stall(input string tag);
      int n = 0;
      int exp;
      #1;
      exp = stall_sb.pop_front();
      for (int i = 0; i < 200 && bus.stall_request; i++) begin
         n++;
         tick();
      end
      chk(tag, 32'(n), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset  = 1'b1;
      stall  = 6'b000000;
      cancel = 1'b0;
      drive(OP_NOP, CATEGORY_NONE, 32'd0, 32'd0, 1'b0, 32'd0, 16'h0000);
      repeat (2) tick();
      reset = 1'b0;
      #1;
      chk("reset.stall_req", 32'(bus.stall_request), 32'd0);
      exec("reset.mfhi", OP_MFHI, CATEGORY_MOVE, 0, 0, 1, 0, 0, 32'h0, 1, 0);
      tick();
      exec("reset.mflo", OP_MFLO, CATEGORY_MOVE, 0, 0, 1, 0, 0, 32'h0, 1, 0);

      tick(); exec("add", OP_ADD, CATEGORY_ARITH, 32'h7FFFFFFF, 32'h1, 1, 0, 0,
                   32'h80000000, 0, 1);
      tick(); exec("addu", OP_ADDU, CATEGORY_ARITH, 32'h7FFFFFFF, 32'h1, 1, 0, 0,
                   32'h80000000, 1, 0);
      tick(); exec("sub", OP_SUB, CATEGORY_ARITH, 32'h80000000, 32'h1, 1, 0, 0,
                   32'h7FFFFFFF, 0, 1);
      tick(); exec("subu", OP_SUBU, CATEGORY_ARITH, 32'h80000000, 32'h1, 1, 0, 0,
                   32'h7FFFFFFF, 1, 0);
      tick(); exec("addi", OP_ADDI, CATEGORY_ARITH, 32'h80000000, 32'hFFFFFFFF, 1, 0, 0,
                   32'h7FFFFFFF, 0, 1);
      tick(); exec("sra", OP_SRA, CATEGORY_SHIFT, 32'd4, 32'h80000000, 1, 0, 0,
                   32'hF8000000, 1, 0);
      tick(); exec("sll", OP_SLL, CATEGORY_SHIFT, 32'd31, 32'h1, 1, 0, 0,
                   32'h80000000, 1, 0);
      tick(); exec("srl", OP_SRL, CATEGORY_SHIFT, 32'd4, 32'h80000000, 1, 0, 0,
                   32'h08000000, 1, 0);
      tick(); exec("sltu", OP_SLTU, CATEGORY_ARITH, 32'h1, 32'hFFFFFFFF, 1, 0, 0, 32'h1, 1, 0);
      tick(); exec("slt", OP_SLT, CATEGORY_ARITH, 32'h1, 32'hFFFFFFFF, 1, 0, 0, 32'h0, 1, 0);
      tick(); exec("and", OP_AND, CATEGORY_LOGIC, 32'hF0F000FF, 32'h0FF00F0F, 1, 0, 0,
                   32'h00F0000F, 1, 0);
      tick(); exec("or", OP_OR, CATEGORY_LOGIC, 32'hF0F000FF, 32'h0FF00F0F, 1, 0, 0,
                   32'hFFF00FFF, 1, 0);
      tick(); exec("xor", OP_XOR, CATEGORY_LOGIC, 32'hF0F000FF, 32'h0FF00F0F, 1, 0, 0,
                   32'hFF000FF0, 1, 0);
      tick(); exec("nor", OP_NOR, CATEGORY_LOGIC, 32'hF0F000FF, 32'h0FF00F0F, 1, 0, 0,
                   32'h000FF000, 1, 0);
      tick(); exec("jump", OP_NOP, CATEGORY_JUMP, 32'h0, 32'h0, 1, 32'h00400008, 0,
                   32'h00400008, 1, 0);
      tick(); exec("lw", OP_LW, CATEGORY_MEMORY, 32'h00001000, 32'hCAFEF00D, 1, 0, 16'hFFFC,
                   32'h0, 1, 0);
      chk("lw.address", bus.mem_address, 32'h00000FFC);
      chk("lw.store_data", bus.mem_store_data, 32'hCAFEF00D);
      chk("lw.instruction", bus.mem_instruction, 32'h0000FFFC);
      chk("lw.operator", 32'(bus.mem_operator), 32'(OP_LW));
      chk("lw.waddr", 32'(bus.mem_reg_write_address), 32'd8);

      tick(); exec("mult", OP_MULT, CATEGORY_NONE, 32'hFFFFFFFF, 32'h2, 0, 0, 0, 32'h0, 0, 0);
      tick(); exec("mult.mfhi", OP_MFHI, CATEGORY_MOVE, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 1, 0);
      tick(); exec("mult.mflo", OP_MFLO, CATEGORY_MOVE, 0, 0, 1, 0, 0, 32'hFFFFFFFE, 1, 0);
      tick(); exec("multu", OP_MULTU, CATEGORY_NONE, 32'hFFFFFFFF, 32'h2, 0, 0, 0, 32'h0, 0, 0);
      tick(); exec("multu.mfhi", OP_MFHI, CATEGORY_MOVE, 0, 0, 1, 0, 0, 32'h1, 1, 0);

      // Signed divide: -7 / 2 = -3 remainder -1.
      tick(); div_issue(OP_DIV, 32'hFFFFFFF9, 32'h2, 33);
      measure_stall("div.stall_cycles");
      tick(); exec("div.mflo", OP_MFLO, CATEGORY_MOVE, 0, 0, 1, 0, 0, 32'hFFFFFFFD, 1, 0);
      tick(); exec("div.mfhi", OP_MFHI, CATEGORY_MOVE, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 1, 0);

      tick(); div_issue(OP_DIVU, 32'h7, 32'h0, 2);
      measure_stall("divz.stall_cycles");
      tick(); exec("divz.mfhi", OP_MFHI, CATEGORY_MOVE, 0, 0, 1, 0, 0, 32'h0, 1, 0);
      tick(); exec("divz.mflo", OP_MFLO, CATEGORY_MOVE, 0, 0, 1, 0, 0, 32'h0, 1, 0);

      // DONE held by a downstream stall for three edges, then committed.
      tick(); div_issue(OP_DIVU, 32'd100, 32'd7, 33);
      measure_stall("hold.stall_cycles");
      stall = 6'b001111;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold.stall_req", 32'(bus.stall_request), 32'd0);
      end
      stall = 6'b000000;
      tick(); exec("hold.mfhi", OP_MFHI, CATEGORY_MOVE, 0, 0, 1, 0, 0, 32'd2, 1, 0);
      tick(); exec("hold.mflo", OP_MFLO, CATEGORY_MOVE, 0, 0, 1, 0, 0, 32'd14, 1, 0);

      // Cancel at RUN cycle 10: no HI/LO write, divider idle again.
      tick(); exec("mthi", OP_MTHI, CATEGORY_NONE, 32'h11111111, 0, 0, 0, 0, 32'h0, 0, 0);
      tick(); exec("mtlo", OP_MTLO, CATEGORY_NONE, 32'h22222222, 0, 0, 0, 0, 32'h0, 0, 0);
      tick(); drive(OP_DIV, CATEGORY_NONE, 32'd100, 32'd7, 1'b0, 32'd0, 16'h0000);
      repeat (11) tick();
      chk("cancel.busy", 32'(bus.stall_request), 32'd1);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      exec("cancel.mfhi", OP_MFHI, CATEGORY_MOVE, 0, 0, 1, 0, 0, 32'h11111111, 1, 0);
      tick(); exec("cancel.mflo", OP_MFLO, CATEGORY_MOVE, 0, 0, 1, 0, 0, 32'h22222222, 1, 0);
      tick(); div_issue(OP_DIVU, 32'h7, 32'h0, 2);
      measure_stall("cancel.idle_after");

      // Reset at RUN cycle 10.
      tick(); exec("mthi2", OP_MTHI, CATEGORY_NONE, 32'h33333333, 0, 0, 0, 0, 32'h0, 0, 0);
      tick(); drive(OP_DIV, CATEGORY_NONE, 32'd100, 32'd7, 1'b0, 32'd0, 16'h0000);
      repeat (11) tick();
      chk("rstdiv.busy", 32'(bus.stall_request), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exec("rstdiv.nop", OP_NOP, CATEGORY_NONE, 0, 0, 0, 0, 0, 32'h0, 0, 0);
      tick(); exec("rstdiv.mfhi", OP_MFHI, CATEGORY_MOVE, 0, 0, 1, 0, 0, 32'h0, 1, 0);
      tick(); exec("rstdiv.mflo", OP_MFLO, CATEGORY_MOVE, 0, 0, 1, 0, 0, 32'h0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
